// File: rtl/mask_xor_scheduler_if.sv
// rtl/mask_xor_scheduler_if.sv - requester/result/config bundle for mask_xor_scheduler
interface mask_xor_scheduler_if #(
  parameter int W = 32
);
  // requester 0
  logic         req0_valid;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_ready;
  // requester 1
  logic         req1_valid;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_ready;
  // result stream
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_id;
  // mask configuration
  logic         cfg_we;
  logic [W-1:0] cfg_mask;
  logic [W-1:0] mask_q;

  // requesters, consumer and configuration master (the environment)
  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  out_valid, out_y, out_id,
    output out_ready,
    output cfg_we, cfg_mask,
    input  mask_q
  );

  // the scheduler itself
  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output out_valid, out_y, out_id,
    input  out_ready,
    input  cfg_we, cfg_mask,
    output mask_q
  );
endinterface

// File: rtl/mask_xor_scheduler.sv
// rtl/mask_xor_scheduler.sv - round-robin shared (a|b)^mask datapath, optional mask write via MASK_XOR_SCHED_CFG_EN
module mask_xor_scheduler #(
  parameter int          W        = 32,
  parameter logic [31:0] MASK_RST = 32'hC000_0003
) (
  input  logic                  clk,
  input  logic                  rst,
  mask_xor_scheduler_if.slave   bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state_q;
  logic [W-1:0] out_y_q;
  logic         out_id_q;
  logic         last_id_q;
  logic [W-1:0] mask_cur;

  logic         grant0;
  logic         grant1;
  logic         can_accept;
  logic         take0;
  logic         take1;
  logic         take_any;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;
  logic [W-1:0] out_y_d;
  logic         out_id_d;

`ifdef MASK_XOR_SCHED_CFG_EN
  logic [W-1:0] mask_val_q;

  // mask register: a write lands on the next edge, so a same-cycle grant still sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_val_q <= W'(MASK_RST);
    end else if (bus.cfg_we) begin
      mask_val_q <= bus.cfg_mask;
    end
  end

  assign mask_cur = mask_val_q;
`else
  // mask is a fixed constant; the config port is present but has no effect
  logic unused_cfg;
  assign unused_cfg = &{1'b0, bus.cfg_we, bus.cfg_mask};
  assign mask_cur   = W'(MASK_RST);
`endif

  assign bus.mask_q = mask_cur;

  // round-robin arbitration: on contention the requester not served last wins
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = last_id_q;
      grant1 = ~last_id_q;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  // the result slot frees up when empty or when it drains this cycle; nothing is accepted in reset
  assign can_accept = ~rst & ((state_q == EMPTY) | bus.out_ready);
  assign take0      = can_accept & grant0;
  assign take1      = can_accept & grant1;
  assign take_any   = take0 | take1;

  assign bus.req0_ready = take0;
  assign bus.req1_ready = take1;

  // shared datapath operand steering and result computation
  always_comb begin
    sel_a    = bus.req0_a;
    sel_b    = bus.req0_b;
    out_id_d = 1'b0;
    if (take1) begin
      sel_a    = bus.req1_a;
      sel_b    = bus.req1_b;
      out_id_d = 1'b1;
    end
    out_y_d = (sel_a | sel_b) ^ mask_cur;
  end

  // result-slot FSM with registered result, tag and round-robin history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      out_y_q   <= '0;
      out_id_q  <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (take_any) begin
            out_y_q   <= out_y_d;
            out_id_q  <= out_id_d;
            last_id_q <= out_id_d;
            state_q   <= FULL;
          end
        end
        FULL: begin
          if (take_any) begin
            out_y_q   <= out_y_d;
            out_id_q  <= out_id_d;
            last_id_q <= out_id_d;
            state_q   <= FULL;
          end else if (bus.out_ready) begin
            state_q   <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_y     = out_y_q;
  assign bus.out_id    = out_id_q;

endmodule

// File: tb/tb_mask_xor_scheduler.sv
// tb/tb_mask_xor_scheduler.sv - self-checking bench for mask_xor_scheduler
module tb_mask_xor_scheduler;

  localparam int          W        = 32;
  localparam logic [31:0] MASK_RST = 32'hC000_0003;

  logic clk;
  logic rst;

  mask_xor_scheduler_if #(.W(W)) bus ();

  mask_xor_scheduler #(.W(W), .MASK_RST(MASK_RST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        y_id;
    logic [31:0] y;
  } res_t;

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        ordy;
    logic        r0;
    logic        r1;
  } vec_t;

  res_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference mask
  always @(posedge clk or posedge rst) begin
    if (rst) model_mask = MASK_RST;
`ifdef MASK_XOR_SCHED_CFG_EN
    else if (bus.cfg_we) model_mask = bus.cfg_mask;
`endif
  end

  // scoreboard: compare results leaving, then record operands accepted
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else if (bus.out_ready) begin
          res_t r;
          r = sb_q.pop_front();
          chk("sb_out_y", bus.out_y, r.y);
          chk("sb_out_id", 32'(bus.out_id), 32'(r.y_id));
        end else begin
          chk("hold_out_y", bus.out_y, sb_q[0].y);
          chk("hold_out_id", 32'(bus.out_id), 32'(sb_q[0].y_id));
        end
      end
      if (bus.req0_ready && bus.req1_ready) chk("both_ready", 32'd1, 32'd0);
      if (bus.req0_ready) sb_q.push_back('{1'b0, (bus.req0_a | bus.req0_b) ^ model_mask});
      if (bus.req1_ready) sb_q.push_back('{1'b1, (bus.req1_a | bus.req1_b) ^ model_mask});
    end
  end

  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic ordy, input logic we, input logic [31:0] wm);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    bus.out_ready  = ordy;
    bus.cfg_we     = we;  bus.cfg_mask = wm;
  endtask

  // one cycle: drive just after the rising edge, return at the falling edge for sampling
  task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic ordy, input logic we, input logic [31:0] wm);
    @(posedge clk);
    #1;
    drive(v0, a0, b0, v1, a1, b1, ordy, we, wm);
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, ordy, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    drive(1'b1, 32'h1, 32'h2, 1'b1, 32'h3, 32'h4, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_00F0, 32'h0000_000F, 1'b1, 32'hFFFF_0000, 32'h0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_00F0, 32'h0000_000F, 1'b1, 32'hFFFF_0000, 32'h0, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 32'h0000_00F0, 32'h0000_000F, 1'b1, 32'hFFFF_0000, 32'h0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_00F0, 32'h0000_000F, 1'b1, 32'hFFFF_0000, 32'h0, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0,         32'h0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 32'h0,         32'h0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 32'h0,         32'h0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 32'h0,         32'h0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 32'h0,         32'h0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    model_mask = MASK_RST;
    drive(1'b1, 32'h1, 32'h2, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_y", bus.out_y, 32'h0);
    chk("reset_out_id", 32'(bus.out_id), 32'd0);
    chk("reset_mask_q", bus.mask_q, MASK_RST);
    chk("reset_req0_ready", 32'(bus.req0_ready), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    rst = 1'b0;

    // contention, idle, single req1, backpressure with drain+refill
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].v1, vecs[i].a1, vecs[i].b1,
           vecs[i].ordy, 1'b0, 32'h0);
      chk($sformatf("vec%0d_req0_ready", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
      chk($sformatf("vec%0d_req1_ready", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
    end

    // single request after reset: accepted in cycle 0, result visible next cycle
    do_reset();
    step(1'b1, 32'h0000_00F0, 32'h0000_000F, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("single_req0_ready", 32'(bus.req0_ready), 32'd1);
    chk("single_out_valid_c0", 32'(bus.out_valid), 32'd0);
    idle(1'b1);
    chk("single_out_valid", 32'(bus.out_valid), 32'd1);
    chk("single_out_y", bus.out_y, 32'hC000_00FC);
    chk("single_out_id", 32'(bus.out_id), 32'd0);

    // mask write coinciding with a grant
    step(1'b1, 32'h0000_00F0, 32'h0000_000F, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_FFFF);
    step(1'b1, 32'h1234_0000, 32'h0000_5678, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("mask_first_out_y", bus.out_y, 32'hC000_00FC);
    idle(1'b1);
`ifdef MASK_XOR_SCHED_CFG_EN
    chk("mask_second_out_y", bus.out_y, 32'h1234_A987);
    chk("mask_q_written", bus.mask_q, 32'h0000_FFFF);
`else
    chk("mask_second_out_y", bus.out_y, 32'hD234_567B);
    chk("mask_q_fixed", bus.mask_q, MASK_RST);
`endif
    idle(1'b1);

    // asynchronous reset while a result is pending
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0F0F_0000, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(1'b0);
    chk("midrst_full", 32'(bus.out_valid), 32'd1);
    #1;
    rst = 1'b1;
    sb_q.delete();
    bus.req0_valid = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_req0_ready", 32'(bus.req0_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 32'h0000_0100, 32'h0, 1'b1, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("post_rst_req0_wins", 32'(bus.req0_ready), 32'd1);
    chk("post_rst_req1_wait", 32'(bus.req1_ready), 32'd0);
    idle(1'b1);
    chk("post_rst_mask", bus.mask_q, MASK_RST);
    idle(1'b1);
    idle(1'b1);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mask_xor_scheduler.md
# mask_xor_scheduler

Shares one masked-OR-XOR datapath, `y = (a | b) ^ mask`, between two requesters. A round-robin arbiter picks one requester per transfer and drives the shared datapath. The result is registered, tagged with the requester ID and handed downstream over a valid/ready handshake. The block sits between two operand producers and a single result consumer, and owns the mask register that configures the datapath constant.

## Interface
Parameters:
- `W`, 32, operand/result width
- `MASK_RST`, 32'hC000_0003, reset value of the mask register (low `W` bits used)

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0_valid` input 1: requester 0 operands valid.
- `req0_a` input W: requester 0 operand a.
- `req0_b` input W: requester 0 operand b.
- `req0_ready` output 1: requester 0 operands accepted this cycle.
- `req1_valid` input 1: requester 1 operands valid.
- `req1_a` input W: requester 1 operand a.
- `req1_b` input W: requester 1 operand b.
- `req1_ready` output 1: requester 1 operands accepted this cycle.
- `out_valid` output 1: result register holds a valid result.
- `out_ready` input 1: consumer accepts the result.
- `out_y` output W: registered `(a | b) ^ mask`.
- `out_id` output 1: ID of the requester that produced `out_y`.
- `cfg_we` input 1: mask write strobe.
- `cfg_mask` input W: new mask value.
- `mask_q` output W: current mask register value.

## Operation
- FSM has two states:
  - EMPTY: result register holds nothing.
  - FULL: result register holds an unconsumed result.
- `can_accept` = (state == EMPTY) | (state == FULL & out_ready).
- Arbitration, evaluated only when `can_accept`:
  - One valid requester: grant it.
  - Both valid: grant the requester that was not granted last (`last_id`).
  - None valid: no grant.
- `reqN_ready` = `can_accept` & grant[N]. The ready signals are combinational and never both high.
- On a grant:
  - `out_y` <= (a | b) ^ `mask_q` using the granted operands.
  - `out_id` <= granted index.
  - `last_id` <= granted index.
  - Next state FULL.
- FULL & `out_ready` with no grant: next state EMPTY.
- FULL & !`out_ready`: hold `out_y`/`out_id`; both ready signals are 0 (backpressure).
- `reqN_valid` without ready: the operands must stay stable. This is a requester obligation and is not checked.
- Arithmetic is pure bitwise, with no carries. All operands and the mask are exactly `W` bits.

## Timing
- Reset values:
  - State EMPTY.
  - `out_valid` = 0, `out_y` = 0, `out_id` = 0.
  - `last_id` = 1, so requester 0 wins the first contention.
  - `mask_q` = `MASK_RST`.
  - Both ready signals 0 while `rst` is high.
- Latency: operands are accepted in cycle n, and `out_valid` with the result is visible after edge n+1.
- Throughput: one result per cycle when `out_ready` is held high. Drain and refill in the same cycle is allowed in FULL.
- Reset asserted mid-transfer: the pending result is discarded and the state returns to EMPTY immediately (asynchronous). Requester handshakes in that cycle do not complete.
- A mask write in cycle n takes effect on edge n+1. A grant in cycle n uses the old mask.

## Configuration
- Macro `MASK_XOR_SCHED_CFG_EN`.
- Defined:
  - `cfg_we` high loads `cfg_mask` into `mask_q` on the next edge.
  - When `cfg_we` and a grant coincide, the grant uses the old mask.
- Undefined:
  - `cfg_we`/`cfg_mask` remain ports but are ignored.
  - `mask_q` is constant `MASK_RST`, and the mask register is not synthesized.

## Test plan
- Single request:
  - Stimulus: after reset, req0 with a=0x0000_00F0, b=0x0000_000F; `out_ready`=1.
  - Response: `req0_ready`=1 in cycle 0; next cycle `out_valid`=1, `out_y`=0xC000_00FC, `out_id`=0.
- Contention:
  - Stimulus: both requesters valid for 4 cycles, req1 with a=0xFFFF_0000, b=0; `out_ready`=1.
  - Response: grants alternate 0,1,0,1; req1 results are 0x3FFF_0003.
- Backpressure:
  - Stimulus: `out_ready`=0 for 3 cycles while FULL.
  - Response: `out_y`/`out_id` stable; both ready signals 0. After `out_ready`=1, drain and refill occur in the same cycle.
- Mask write (with `MASK_XOR_SCHED_CFG_EN`):
  - Stimulus: write 0x0000_FFFF in the same cycle as a grant, then grant a=0x1234_0000, b=0x0000_5678.
  - Response: the first result uses 0xC000_0003; the second is 0x1234_A987. Without the macro, the second result is 0xD234_567B.
- Reset mid-operation:
  - Stimulus: assert `rst` while FULL with `out_valid`=1.
  - Response: `out_valid`=0 immediately; after release, req0 wins the first contention.
